imem_boot: RTL and testbench

Parametrised, loadable instruction memory for the pipelined CPU, replacing the fixed-content instruction store. After reset it clears itself to NOPs and then accepts a program over a valid/ready load stream. Once the program is in, it releases the core (`run`) and serves one registered 32-bit fetch per cycle, with stall and fault reporting. It sits between the IF stage and the board-level program loader (UART/debug bridge).

---
 rtl/imem_boot.sv | 162 ++++++++++++++++
 tb/tb_imem_boot.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot
//  Description : Loadable instruction memory. Clears itself to NOP after
//                reset, accepts a program over a valid/ready stream, then
//                serves one registered 32-bit fetch per cycle with fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot #(
   parameter int          ADDR_WIDTH     = 10,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,        // asynchronous, active-low
   input  logic [31:0]           iaddr,
   input  logic                  fetch_en,
   output logic [31:0]           idata,
   output logic                  ivalid,
   output logic                  ifault,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   input  logic                  reload,
   output logic                  run,
   output logic                  load_ovf,
   output logic [ADDR_WIDTH-2:0] load_count
);

   localparam int PW    = ADDR_WIDTH - 2;   // word pointer width
   localparam int CW    = ADDR_WIDTH - 1;   // load counter width (holds DEPTH)
   localparam int DEPTH = 1 << PW;

   localparam logic [PW-1:0] PTR_LAST = '1;
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_LOAD;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     idata_q, idata_d;
   logic            ivalid_q, ivalid_d;
   logic            ifault_q, ifault_d;
   logic            we;
   logic [31:0]     wdata;
   logic            fault;
   logic [31:0]     mem_q [DEPTH];

   // Misaligned address or any bit above the decoded range is a fault.
   assign fault = (iaddr[1:0] != 2'b00) || ((iaddr >> ADDR_WIDTH) != 32'd0);

   // Next-state, write port and fetch result decode.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      we       = 1'b0;
      wdata    = NOP_WORD;
      idata_d  = NOP_WORD;
      ivalid_d = 1'b0;
      ifault_d = 1'b0;
      case (state_q)
         S_CLEAR: begin
            we    = 1'b1;
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               state_d = S_LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (ld_valid) begin
               we    = 1'b1;
               wdata = ld_data;
               ptr_d = ptr_q + PTR_ONE;   // wraps to 0 after the last word
               cnt_d = cnt_q + CNT_ONE;
               if (ld_last) begin
                  state_d = S_RUN;
               end else if (ptr_q == PTR_LAST) begin
                  state_d = S_RUN;
                  ovf_d   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (reload) begin
               state_d = S_LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RESET_STATE;
            ptr_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // Fetch port: active only in RUN, holds when stalled.
      if (state_q == S_RUN) begin
         if (fetch_en) begin
            ivalid_d = 1'b1;
            ifault_d = fault;
            idata_d  = fault ? NOP_WORD : mem_q[iaddr[ADDR_WIDTH-1:2]];
         end else begin
            idata_d  = idata_q;
            ivalid_d = ivalid_q;
            ifault_d = ifault_q;
         end
      end
   end

   // Control and fetch output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RESET_STATE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         idata_q  <= NOP_WORD;
         ivalid_q <= 1'b0;
         ifault_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         idata_q  <= idata_d;
         ivalid_q <= ivalid_d;
         ifault_q <= ifault_d;
      end
   end

   // Storage array; only CLEAR and LOAD write it, never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[ptr_q] <= wdata;
      end
   end

   assign idata      = idata_q;
   assign ivalid     = ivalid_q;
   assign ifault     = ifault_q;
   assign ld_ready   = (state_q == S_LOAD);
   assign run        = (state_q == S_RUN);
   assign load_ovf   = ovf_q;
   assign load_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot
//  Description : Scoreboard bench for imem_boot (ADDR_WIDTH=10, clear on).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot;

   localparam int          AW    = 10;
   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   iaddr = '0;
   logic          fetch_en = 1'b0;
   logic [31:0]   idata;
   logic          ivalid, ifault;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [31:0]   ld_data = '0;
   logic          ld_last = 1'b0;
   logic          reload = 1'b0;
   logic          run, load_ovf;
   logic [AW-2:0] load_count;

   typedef struct {
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model [DEPTH];
   int          mptr;
   int          n_checks = 0;
   int          n_errors = 0;

   imem_boot #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .iaddr(iaddr), .fetch_en(fetch_en),
      .idata(idata), .ivalid(ivalid), .ifault(ifault),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_last(ld_last), .reload(reload), .run(run),
      .load_ovf(load_ovf), .load_count(load_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge. Pending fetch
   // results are compared against the scoreboard here.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("fetch_idata",  idata,  e.data);
         check("fetch_ifault", {31'd0, ifault}, {31'd0, e.fault});
         check("fetch_ivalid", {31'd0, ivalid}, 32'd1);
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      exp_t e;
      e.fault = (a[1:0] != 2'b00) || ((a >> AW) != 32'd0);
      e.data  = e.fault ? NOP : model[a[AW-1:2]];
      sb_q.push_back(e);
      iaddr    = a;
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      check("ld_ready_before_hs", {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      model[mptr % DEPTH] = d;
      mptr++;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // Release reset and count cycles until ld_ready rises (bounded).
   task automatic release_and_clear();
      int n;
      for (int i = 0; i < DEPTH; i++) model[i] = NOP;
      mptr = 0;
      rst  = 1'b1;
      n    = 0;
      check("ld_ready_in_clear", {31'd0, ld_ready}, 32'd0);
      while (!ld_ready && n < 400) begin
         tick();
         n++;
      end
      check("clear_cycles", n, DEPTH);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      mptr   = 0;
   endtask

   initial begin
      // Reset values
      repeat (3) tick();
      check("rst_idata",      idata, NOP);
      check("rst_ivalid",     {31'd0, ivalid}, 32'd0);
      check("rst_ifault",     {31'd0, ifault}, 32'd0);
      check("rst_run",        {31'd0, run}, 32'd0);
      check("rst_load_ovf",   {31'd0, load_ovf}, 32'd0);
      check("rst_load_count", {23'd0, load_count}, 32'd0);
      check("rst_ld_ready",   {31'd0, ld_ready}, 32'd0);

      // CLEAR lasts DEPTH cycles, then single-word program
      release_and_clear();
      check("load_count_start", {23'd0, load_count}, 32'd0);
      load_word(32'h3c01_1001, 1'b1);
      check("run_after_last", {31'd0, run}, 32'd1);
      check("count_1", {23'd0, load_count}, 32'd1);
      fetch(32'h4);
      fetch(32'h0);

      // reload together with a fetch: fetch completes, then LOAD
      sb_q.push_back('{data: 32'h3c01_1001, fault: 1'b0});
      iaddr = 32'h0; fetch_en = 1'b1; reload = 1'b1;
      tick();
      fetch_en = 1'b0; reload = 1'b0; mptr = 0;
      check("reload_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("reload_run",      {31'd0, run}, 32'd0);
      check("reload_count",    {23'd0, load_count}, 32'd0);
      tick();
      check("load_ivalid_low", {31'd0, ivalid}, 32'd0);
      check("load_idata_nop",  idata, NOP);

      // Three-word program
      load_word(32'h3c01_1001, 1'b0);
      load_word(32'h343d_0004, 1'b0);
      check("run_before_last", {31'd0, run}, 32'd0);
      load_word(32'h3c08_0008, 1'b1);
      check("run_3", {31'd0, run}, 32'd1);
      check("count_3", {23'd0, load_count}, 32'd3);
      check("ovf_3", {31'd0, load_ovf}, 32'd0);
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);

      // Stall: outputs hold while iaddr moves
      fetch(32'h4);
      for (int i = 0; i < 3; i++) begin
         iaddr = 32'h8 - (i * 4);
         tick();
         check("stall_idata",  idata, 32'h343d_0004);
         check("stall_ivalid", {31'd0, ivalid}, 32'd1);
      end

      // Faults
      fetch(32'h6);
      fetch(32'h400);
      fetch(32'h8000_0000);
      fetch(32'h0);
      fetch(32'h3fc);   // retains CLEAR contents

      // Overflow: 256 words without ld_last
      do_reload();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("run_before_ovf", {31'd0, run}, 32'd0);
         load_word(32'ha500_0000 + i, 1'b0);
      end
      check("ovf_run",      {31'd0, run}, 32'd1);
      check("ovf_flag",     {31'd0, load_ovf}, 32'd1);
      check("ovf_count",    {23'd0, load_count}, 32'd256);
      check("ovf_ld_ready", {31'd0, ld_ready}, 32'd0);
      fetch(32'h3fc);
      fetch(32'h8);

      // load_ovf survives reload
      do_reload();
      check("ovf_sticky", {31'd0, load_ovf}, 32'd1);
      load_word(32'h1234_5678, 1'b0);
      load_word(32'h9abc_def0, 1'b0);
      check("count_mid", {23'd0, load_count}, 32'd2);

      // Asynchronous reset mid-load
      #3 rst = 1'b0;
      #1;
      check("arst_load_count", {23'd0, load_count}, 32'd0);
      check("arst_load_ovf",   {31'd0, load_ovf}, 32'd0);
      check("arst_ld_ready",   {31'd0, ld_ready}, 32'd0);
      check("arst_run",        {31'd0, run}, 32'd0);
      check("arst_ivalid",     {31'd0, ivalid}, 32'd0);
      check("arst_idata",      idata, NOP);
      tick();
      release_and_clear();
      load_word(32'h1111_1111, 1'b1);
      check("run_after_rst_load", {31'd0, run}, 32'd1);
      fetch(32'h4);
      fetch(32'h0);
      fetch(32'h3f8);
      tick();
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
